adj_fetch_ctrl: RTL

ADJ_FETCH_CTRL -- requirements
Module: adj_fetch_ctrl

---
 rtl/adj_fetch_ctrl.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/adj_fetch_ctrl.sv
// adj_fetch_ctrl
//   Walks every interior pixel of a frame (the one-pixel border is never a
//   centre). For each centre it reads the 8 neighbours from the frame buffer,
//   forwards each returned byte to an external 8-register store, and then
//   presents the centre to a datapath until dpReady is sampled high.
//
//   Optional build macro: ADJ_FETCH_CENTER_EN
//     defined   - a 9th read fetches the centre pixel itself; the byte is
//                 captured into centerPix and is not written to the store.
//     undefined - 8 reads per centre, centerPix is tied to zero.
//
// Ports
//   clock, nReset          system clock (rising edge), async active-low reset
//   start                  one-cycle frame request, honoured only when idle
//   fbRead/fbAddr          frame-buffer read strobe and linear address y*IMG_W+x
//   fbRdData               read data, valid the cycle after fbRead
//   regAddr/regData        neighbour index / value toward the register store
//   regWrEn                cycle carries a newly read neighbour
//   matReaden, pixValid    neighbour set complete, centre offered to datapath
//   dpReady                datapath accepts the offered centre
//   centerAddr, centerPix  linear address / value of the current centre
//   busy, frameDone        frame in progress / one-cycle end-of-frame pulse
//
// State    | meaning
// IDLE     | waiting for start
// ISSUE    | one frame-buffer read per cycle, neighbour k = 0..N_RD-1
// DRAIN    | two cycles for the last read data to reach the store
// PRESENT  | centre offered, held until dpReady
// DONE     | frameDone pulse, back to IDLE

module adj_fetch_ctrl #(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int ADDR_W = 12
) (
  input  logic              clock,
  input  logic              nReset,
  input  logic              start,
  output logic              fbRead,
  output logic [ADDR_W-1:0] fbAddr,
  input  logic [7:0]        fbRdData,
  output logic [2:0]        regAddr,
  output logic [7:0]        regData,
  output logic              regWrEn,
  output logic              matReaden,
  output logic              pixValid,
  input  logic              dpReady,
  output logic [ADDR_W-1:0] centerAddr,
  output logic [7:0]        centerPix,
  output logic              busy,
  output logic              frameDone
);

`ifdef ADJ_FETCH_CENTER_EN
  localparam int N_RD = 9;
  localparam int KW   = 4;
`else
  localparam int N_RD = 8;
  localparam int KW   = 3;
`endif

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  localparam logic [XW-1:0]     X_LAST = XW'(IMG_W - 2);
  localparam logic [YW-1:0]     Y_LAST = YW'(IMG_H - 2);
  localparam logic [ADDR_W-1:0] W_A    = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);
  localparam logic [KW-1:0]     K_LAST = KW'(N_RD - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    DRAIN   = 3'd2,
    PRESENT = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [KW-1:0]     tmr_q, tmr_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [ADDR_W-1:0] center_q, center_d;
  logic [KW-1:0]     k;
  logic              rd_pend_q;
  logic [KW-1:0]     rd_k_q;

  // The timer counts down through ISSUE, so the neighbour index runs upward.
  assign k = K_LAST - tmr_q;

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q  <= IDLE;
      tmr_q    <= '0;
      x_q      <= XW'(1);
      y_q      <= YW'(1);
      center_q <= '0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      x_q      <= x_d;
      y_q      <= y_d;
      center_q <= center_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    x_d       = x_q;
    y_d       = y_q;
    center_d  = center_q;
    fbRead    = 1'b0;
    fbAddr    = '0;
    matReaden = 1'b0;
    pixValid  = 1'b0;
    busy      = 1'b0;
    frameDone = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = ISSUE;
          tmr_d    = K_LAST;
          x_d      = XW'(1);
          y_d      = YW'(1);
          center_d = W_A + ONE_A;
        end
      end

      ISSUE: begin
        busy   = 1'b1;
        fbRead = 1'b1;
        case (k)
          KW'(0):  fbAddr = center_q - W_A - ONE_A;
          KW'(1):  fbAddr = center_q - W_A;
          KW'(2):  fbAddr = center_q - W_A + ONE_A;
          KW'(3):  fbAddr = center_q + ONE_A;
          KW'(4):  fbAddr = center_q + W_A + ONE_A;
          KW'(5):  fbAddr = center_q + W_A;
          KW'(6):  fbAddr = center_q + W_A - ONE_A;
          KW'(7):  fbAddr = center_q - ONE_A;
          default: fbAddr = center_q;
        endcase
        if (tmr_q == '0) begin
          state_d = DRAIN;
          tmr_d   = KW'(1);
        end else begin
          tmr_d = tmr_q - KW'(1);
        end
      end

      DRAIN: begin
        busy = 1'b1;
        if (tmr_q == '0) state_d = PRESENT;
        else             tmr_d   = tmr_q - KW'(1);
      end

      PRESENT: begin
        busy      = 1'b1;
        matReaden = 1'b1;
        pixValid  = 1'b1;
        if (dpReady) begin
          if (x_q == X_LAST && y_q == Y_LAST) begin
            state_d = DONE;
          end else begin
            state_d = ISSUE;
            tmr_d   = K_LAST;
            if (x_q == X_LAST) begin
              // Last interior pixel of the row to first interior pixel of
              // the next row skips the two border pixels in between.
              x_d      = XW'(1);
              y_d      = y_q + YW'(1);
              center_d = center_q + ADDR_W'(3);
            end else begin
              x_d      = x_q + XW'(1);
              center_d = center_q + ONE_A;
            end
          end
        end
      end

      DONE: begin
        frameDone = 1'b1;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign centerAddr = center_q;

  // Read return pipeline: remember which k was read so the byte arriving the
  // next cycle can be registered toward the store one cycle later.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      rd_pend_q <= 1'b0;
      rd_k_q    <= '0;
    end else begin
      rd_pend_q <= fbRead;
      rd_k_q    <= k;
    end
  end

`ifdef ADJ_FETCH_CENTER_EN
  logic [7:0] center_pix_q;

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      regWrEn      <= 1'b0;
      regAddr      <= '0;
      regData      <= '0;
      center_pix_q <= '0;
    end else if (rd_pend_q && rd_k_q == K_LAST) begin
      regWrEn      <= 1'b0;
      center_pix_q <= fbRdData;
    end else if (rd_pend_q) begin
      regWrEn <= 1'b1;
      regAddr <= rd_k_q[2:0];
      regData <= fbRdData;
    end else begin
      regWrEn <= 1'b0;
    end
  end

  assign centerPix = center_pix_q;
`else
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      regWrEn <= 1'b0;
      regAddr <= '0;
      regData <= '0;
    end else if (rd_pend_q) begin
      regWrEn <= 1'b1;
      regAddr <= rd_k_q;
      regData <= fbRdData;
    end else begin
      regWrEn <= 1'b0;
    end
  end

  assign centerPix = 8'd0;
`endif

endmodule
